instr_ctrl: RTL and testbench

Instruction controller for the 16-bit Lab 6 CPU. It sits directly downstream of the fetch stage (PC, instruction RAM, IR) and consumes the latched 16-bit instruction word. It is a Moore state machine that sequences the fetch stage (PC reset/increment, IR load, RAM address select, RAM write) and the register-file/ALU datapath. It issues one instruction at a time, returning to fetch after each.

---
 rtl/ctrl_pkg.sv | 31 +++
 rtl/instr_decode.sv | 26 ++
 rtl/instr_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_instr_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the Lab 6 CPU instruction controller.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST, S_IF1, S_IF2, S_UPDATEPC, S_DECODE,
    S_WIMM, S_GETA, S_GETB, S_EXEC, S_WREG,
    S_ADDR, S_MEMRD, S_LDWB, S_GETRD, S_MEMWR,
    S_HALT
  } state_t;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_MEM     = 2'b00;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b01;
  localparam logic [1:0] VSEL_MDATA = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

endpackage

// File: rtl/instr_decode.sv
// Field extraction and immediate sign extension for the 16-bit instruction word.
module instr_decode #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] ir,
  output logic [2:0]            opcode,
  output logic [1:0]            op,
  output logic [2:0]            rn,
  output logic [2:0]            rd,
  output logic [1:0]            sh,
  output logic [2:0]            rm,
  output logic [DATA_WIDTH-1:0] sximm5,
  output logic [DATA_WIDTH-1:0] sximm8
);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign sximm5 = {{(DATA_WIDTH-5){ir[4]}}, ir[4:0]};
  assign sximm8 = {{(DATA_WIDTH-8){ir[7]}}, ir[7:0]};

endmodule

// File: rtl/instr_ctrl.sv
// Moore instruction controller: sequences fetch and the register-file/ALU datapath.
// Optional HALT_EN: opcode 111 parks the FSM in HALT (exit by reset) and adds the halted port.
//
// state    | meaning
// RST      | reset_pc asserted, everything else idle
// IF1/IF2  | RAM addressed by PC; IF2 loads IR
// UPDATEPC | PC <= PC+1
// DECODE   | dispatch on opcode/op
// WIMM     | Rn <= sximm8
// GETA     | A <= Rn
// GETB     | B <= Rm
// EXEC     | C <= ALU (or status only for CMP)
// WREG     | Rd <= C
// ADDR     | C <= A + sximm5
// MEMRD    | RAM addressed by C, first cycle
// LDWB     | Rd <= RAM data
// GETRD    | B <= Rd
// MEMWR    | RAM[C] <= B
// HALT     | stopped until reset
module instr_ctrl
  import ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] ir,
  output logic                  reset_pc,
  output logic                  loadpc,
  output logic                  loadir,
  output logic                  msel,
  output logic                  mwrite,
  output logic [2:0]            num,
  output logic [1:0]            vsel,
  output logic                  write,
  output logic                  loada,
  output logic                  loadb,
  output logic                  loadc,
  output logic                  loads,
  output logic                  asel,
  output logic                  bsel,
  output logic [1:0]            alu_op,
  output logic [1:0]            shift,
  output logic [DATA_WIDTH-1:0] sximm5,
  output logic [DATA_WIDTH-1:0] sximm8
`ifdef HALT_EN
  ,
  output logic                  halted
`endif
);

  state_t state, state_nxt;

  logic [2:0]            opcode, rn, rd, rm;
  logic [1:0]            op, sh;
  logic [DATA_WIDTH-1:0] dec_sximm5, dec_sximm8;
  logic                  is_mov, is_cmp;

  instr_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
    .ir     (ir),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .sh     (sh),
    .rm     (rm),
    .sximm5 (dec_sximm5),
    .sximm8 (dec_sximm8)
  );

  assign is_mov = (opcode == OPC_MOV);
  assign is_cmp = (opcode == OPC_ALU) && (op == OP_CMP);

  always_ff @(posedge clk) begin
    if (reset) state <= S_RST;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IF1;
    case (state)
      S_RST:      state_nxt = S_IF1;
      S_IF1:      state_nxt = S_IF2;
      S_IF2:      state_nxt = S_UPDATEPC;
      S_UPDATEPC: state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OPC_MOV: begin
            if (op == OP_MOV_IMM)      state_nxt = S_WIMM;
            else if (op == OP_MOV_REG) state_nxt = S_GETB;
            else                       state_nxt = S_IF1;
          end
          OPC_ALU: state_nxt = S_GETA;
          OPC_LDR, OPC_STR: state_nxt = (op == OP_MEM) ? S_GETA : S_IF1;
`ifdef HALT_EN
          OPC_HALT: state_nxt = S_HALT;
`endif
          default: state_nxt = S_IF1;
        endcase
      end
      S_WIMM:  state_nxt = S_IF1;
      S_GETA:  state_nxt = (opcode == OPC_ALU) ? S_GETB : S_ADDR;
      S_GETB:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = is_cmp ? S_IF1 : S_WREG;
      S_WREG:  state_nxt = S_IF1;
      S_ADDR:  state_nxt = (opcode == OPC_LDR) ? S_MEMRD : S_GETRD;
      S_MEMRD: state_nxt = S_LDWB;
      S_LDWB:  state_nxt = S_IF1;
      S_GETRD: state_nxt = S_MEMWR;
      S_MEMWR: state_nxt = S_IF1;
`ifdef HALT_EN
      S_HALT:  state_nxt = S_HALT;
`else
      S_HALT:  state_nxt = S_IF1;
`endif
      default: state_nxt = S_RST;
    endcase
  end

  always_comb begin
    reset_pc = 1'b0;
    loadpc   = 1'b0;
    loadir   = 1'b0;
    msel     = 1'b0;
    mwrite   = 1'b0;
    num      = rn;
    vsel     = VSEL_C;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    alu_op   = ALU_ADD;
    shift    = 2'b00;
    sximm5   = dec_sximm5;
    sximm8   = dec_sximm8;
`ifdef HALT_EN
    halted   = 1'b0;
`endif
    case (state)
      S_RST: begin
        reset_pc = 1'b1;
        num      = 3'd0;
        sximm5   = '0;
        sximm8   = '0;
      end
      S_IF2:      loadir = 1'b1;
      S_UPDATEPC: loadpc = 1'b1;
      S_WIMM: begin
        num   = rn;
        vsel  = VSEL_IMM8;
        write = 1'b1;
      end
      S_GETA: begin
        num   = rn;
        loada = 1'b1;
      end
      S_GETB: begin
        num   = rm;
        loadb = 1'b1;
      end
      // MOV Rd,Rm passes B through the adder with A forced to zero
      S_EXEC: begin
        asel   = is_mov;
        alu_op = is_mov ? ALU_ADD : op;
        shift  = sh;
        loads  = is_cmp;
        loadc  = !is_cmp;
      end
      S_WREG: begin
        num   = rd;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_MEMRD: msel = 1'b1;
      S_LDWB: begin
        msel  = 1'b1;
        num   = rd;
        vsel  = VSEL_MDATA;
        write = 1'b1;
      end
      S_GETRD: begin
        num   = rd;
        loadb = 1'b1;
      end
      S_MEMWR: begin
        msel   = 1'b1;
        mwrite = 1'b1;
      end
      S_HALT: begin
        num    = 3'd0;
        sximm5 = '0;
        sximm8 = '0;
`ifdef HALT_EN
        halted = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_ctrl.sv
// Directed bench for instr_ctrl: per-cycle expected outputs queued by stimulus, checked by a monitor.
module tb_instr_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ir;
  logic        reset_pc, loadpc, loadir, msel, mwrite;
  logic [2:0]  num;
  logic [1:0]  vsel, alu_op, shift;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic [15:0] sximm5, sximm8;
  logic        halted_act;

  always #5 clk = ~clk;

`ifdef HALT_EN
  logic halted;
  assign halted_act = halted;
`else
  assign halted_act = 1'b0;
`endif

  instr_ctrl #(.DATA_WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .ir       (ir),
    .reset_pc (reset_pc),
    .loadpc   (loadpc),
    .loadir   (loadir),
    .msel     (msel),
    .mwrite   (mwrite),
    .num      (num),
    .vsel     (vsel),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .alu_op   (alu_op),
    .shift    (shift),
    .sximm5   (sximm5),
    .sximm8   (sximm8)
`ifdef HALT_EN
    ,
    .halted   (halted)
`endif
  );

  // control bits: reset_pc loadpc loadir msel mwrite vsel[2] write loada loadb loadc loads asel bsel alu_op[2] shift[2]
  localparam logic [17:0] C_RP   = 18'h20000;
  localparam logic [17:0] C_PC   = 18'h10000;
  localparam logic [17:0] C_IR   = 18'h08000;
  localparam logic [17:0] C_MS   = 18'h04000;
  localparam logic [17:0] C_MW   = 18'h02000;
  localparam logic [17:0] C_V01  = 18'h00800;
  localparam logic [17:0] C_V10  = 18'h01000;
  localparam logic [17:0] C_WR   = 18'h00400;
  localparam logic [17:0] C_LA   = 18'h00200;
  localparam logic [17:0] C_LB   = 18'h00100;
  localparam logic [17:0] C_LC   = 18'h00080;
  localparam logic [17:0] C_LS   = 18'h00040;
  localparam logic [17:0] C_AS   = 18'h00020;
  localparam logic [17:0] C_BS   = 18'h00010;
  localparam logic [17:0] C_SUB  = 18'h00004;
  localparam logic [17:0] C_SH01 = 18'h00001;
  localparam logic [17:0] C_NONE = 18'h00000;

  wire [17:0] ctl_act = {reset_pc, loadpc, loadir, msel, mwrite, vsel, write,
                         loada, loadb, loadc, loads, asel, bsel, alu_op, shift};

  typedef struct packed {
    logic [17:0] ctl;
    logic        halted;
    logic        chk_num;
    logic [2:0]  num;
    logic        chk_x;
    logic [15:0] x5;
    logic [15:0] x8;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  int    vectors = 0;
  int    miscompares = 0;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t  e;
      string n;
      logic  bad;
      e = sb.pop_front();
      n = sb_name.pop_front();
      vectors++;
      bad = (ctl_act !== e.ctl) || (halted_act !== e.halted) ||
            (e.chk_num && (num !== e.num)) ||
            (e.chk_x && ((sximm5 !== e.x5) || (sximm8 !== e.x8)));
      if (bad) begin
        miscompares++;
        $display("FAIL %s: got ctl=%05h halted=%b num=%0d sximm5=%04h sximm8=%04h, want ctl=%05h halted=%b num=%0d sximm5=%04h sximm8=%04h",
                 n, ctl_act, halted_act, num, sximm5, sximm8, e.ctl, e.halted, e.num, e.x5, e.x8);
      end
    end
  end

  task automatic step(input string name, input logic [17:0] c, input logic h,
                      input logic cn, input logic [2:0] n,
                      input logic cx, input logic [15:0] x5, input logic [15:0] x8);
    exp_t e;
    e = '{ctl: c, halted: h, chk_num: cn, num: n, chk_x: cx, x5: x5, x8: x8};
    sb.push_back(e);
    sb_name.push_back(name);
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string name, input logic [17:0] c);
    step(name, c, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic stn(input string name, input logic [17:0] c, input logic [2:0] n);
    step(name, c, 1'b0, 1'b1, n, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic fetch(input logic [15:0] v);
    ir = v;
    st("if1", C_NONE);
    st("if2", C_IR);
    st("updatepc", C_PC);
    st("decode", C_NONE);
  endtask

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: run did not end, want finish before 200000");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    ir    = 16'h0000;
    @(posedge clk);
    #1;
    st("rst_held", C_RP);
    reset = 1'b0;
    st("rst_release", C_RP);

    // MOV R0,#-1
    fetch(16'hD0FF);
    step("wimm", C_V01 | C_WR, 1'b0, 1'b1, 3'd0, 1'b1, 16'hFFFF, 16'hFFFF);

    // ADD R2,R1,R0 LSL#1
    fetch(16'hA148);
    stn("add_geta", C_LA, 3'd1);
    stn("add_getb", C_LB, 3'd0);
    st("add_exec", C_LC | C_SH01);
    stn("add_wreg", C_WR, 3'd2);

    // CMP R1,R0 LSL#1
    fetch(16'hA948);
    stn("cmp_geta", C_LA, 3'd1);
    stn("cmp_getb", C_LB, 3'd0);
    st("cmp_exec", C_LS | C_SUB | C_SH01);

    // MOV R1,R2 LSL#1
    fetch(16'hC02A);
    stn("movr_getb", C_LB, 3'd2);
    st("movr_exec", C_AS | C_LC | C_SH01);
    stn("movr_wreg", C_WR, 3'd1);

    // STR R3,[R1,#2]
    fetch(16'h8162);
    stn("str_geta", C_LA, 3'd1);
    step("str_addr", C_BS | C_LC, 1'b0, 1'b0, 3'd0, 1'b1, 16'h0002, 16'h0062);
    stn("str_getrd", C_LB, 3'd3);
    st("str_memwr", C_MS | C_MW);

    // LDR R3,[R1,#-1]
    fetch(16'h617F);
    stn("ldr_geta", C_LA, 3'd1);
    step("ldr_addr", C_BS | C_LC, 1'b0, 1'b0, 3'd0, 1'b1, 16'hFFFF, 16'h007F);
    st("ldr_memrd", C_MS);
    stn("ldr_ldwb", C_MS | C_V10 | C_WR, 3'd3);

    // undefined opcode is a NOP
    fetch(16'h0000);

    // reset during GETB aborts the ADD before write-back
    fetch(16'hA148);
    stn("abort_geta", C_LA, 3'd1);
    reset = 1'b1;
    stn("abort_getb", C_LB, 3'd0);
    reset = 1'b0;
    st("abort_rst", C_RP);

    fetch(16'hE000);
`ifdef HALT_EN
    for (int i = 0; i < 3; i++) step("halt_hold", C_NONE, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
    reset = 1'b1;
    step("halt_exit", C_NONE, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
    reset = 1'b0;
    st("halt_rst", C_RP);
`endif

    ir = 16'hD0FF;
    st("final_if1", C_NONE);
    st("final_if2", C_IR);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
